controle_mao: RTL and testbench

- Hand sequencer for the truco scoreboard.
- Tracks round results within one hand (best of 3) and the current stake (raised by truco requests).
- At hand end, issues one-cycle increment pulses into the two 3-bit score counters (team A and team B), one pulse per stake point.
- Then pulses ClrM to clear per-hand state, and flags game end when a team reaches the target score.

---
 rtl/controle_mao_pkg.sv | 32 +++
 rtl/controle_mao_historico_rodadas.sv | 70 +++++++
 rtl/controle_mao.sv | 161 ++++++++++++++++
 tb/tb_controle_mao.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/controle_mao_pkg.sv
// rtl/controle_mao_pkg.sv - shared encodings for the truco hand sequencer
package controle_mao_pkg;

  typedef enum logic [2:0] {
    JOGA   = 3'd0,
    PEDIDO = 3'd1,
    PONTUA = 3'd2,
    LIMPA  = 3'd3,
    FIM    = 3'd4
  } estado_t;

  localparam logic EQUIPE_A = 1'b0;
  localparam logic EQUIPE_B = 1'b1;

  typedef enum logic [1:0] {
    NADA    = 2'b00,
    GANHA_A = 2'b01,
    GANHA_B = 2'b10,
    EMPATE  = 2'b11
  } resultado_t;

  // A round that was actually won by someone (not empty, not tied)
  function automatic logic eh_vitoria(input resultado_t r);
    return (r == GANHA_A) || (r == GANHA_B);
  endfunction

  // Team that won a round; only meaningful when eh_vitoria(r)
  function automatic logic equipe_de(input resultado_t r);
    return (r == GANHA_B) ? EQUIPE_B : EQUIPE_A;
  endfunction

endpackage

// File: rtl/controle_mao_historico_rodadas.sv
// rtl/controle_mao_historico_rodadas.sv - three-round history and hand decision
module historico_rodadas
  import controle_mao_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  logic       grava,
  input  logic       limpa,
  input  resultado_t resultado,
  output logic       decidida,
  output logic       vencedor_mao,
  output logic       sem_pontos
);

  resultado_t r1, r2, r3;
  logic [1:0] rodada;

  // Record each round result into the next free slot; cleared between hands
  always_ff @(posedge clk) begin
    if (clr || limpa) begin
      r1     <= NADA;
      r2     <= NADA;
      r3     <= NADA;
      rodada <= 2'd0;
    end else if (grava && (rodada != 2'd3)) begin
      case (rodada)
        2'd0:    r1 <= resultado;
        2'd1:    r2 <= resultado;
        default: r3 <= resultado;
      endcase
      rodada <= rodada + 2'd1;
    end
  end

  // Decide the hand from the rounds played so far (any three results decide)
  always_comb begin
    decidida     = 1'b0;
    vencedor_mao = EQUIPE_A;
    sem_pontos   = 1'b0;
    if (r1 == EMPATE) begin
      if (eh_vitoria(r2)) begin
        decidida     = 1'b1;
        vencedor_mao = equipe_de(r2);
      end else if (r2 == EMPATE) begin
        if (eh_vitoria(r3)) begin
          decidida     = 1'b1;
          vencedor_mao = equipe_de(r3);
        end else if (r3 == EMPATE) begin
          decidida   = 1'b1;
          sem_pontos = 1'b1;
        end
      end
    end else if (eh_vitoria(r1)) begin
      if ((r2 == r1) || (r2 == EMPATE)) begin
        decidida     = 1'b1;
        vencedor_mao = equipe_de(r1);
      end else if (r2 != NADA) begin
        // rounds split 1-1: a tie in round 3 goes to the round-1 winner
        if (r3 == EMPATE) begin
          decidida     = 1'b1;
          vencedor_mao = equipe_de(r1);
        end else if (eh_vitoria(r3)) begin
          decidida     = 1'b1;
          vencedor_mao = equipe_de(r3);
        end
      end
    end
  end

endmodule

// File: rtl/controle_mao.sv
// rtl/controle_mao.sv - truco hand sequencer: rounds, stake, scoring pulses, game end
module controle_mao
  import controle_mao_pkg::*;
#(
  parameter int PONTOS_JOGO = 7,
  parameter int VALOR_MAX   = 4
) (
  input  logic       Clk,
  input  logic       Clr,
  input  logic       VenceA,
  input  logic       VenceB,
  input  logic       Empate,
  input  logic       Truco,
  input  logic       Aceita,
  input  logic       Corre,
  input  logic [2:0] PA,
  input  logic [2:0] PB,
  output logic       IncA,
  output logic       IncB,
  output logic       ClrM,
  output logic [2:0] Valor,
  output logic       Vez,
  output logic       Pedido,
  output logic       FimJogo,
  output logic       Vencedor
);

  localparam logic [3:0] META = 4'(PONTOS_JOGO);
  localparam logic [2:0] VMAX = 3'(VALOR_MAX);

  estado_t    estado, estado_n;
  logic       ganhador, ganhador_n, requerente, requerente_n;
  logic [2:0] conta, conta_n, valor_n;
  logic [3:0] pontos, pontos_n;
  logic       inca_n, incb_n, clrm_n, vez_n, pedido_n, fim_n, venc_n;
  logic       decidida, vencedor_mao, sem_pontos, grava, rodada_in;
  resultado_t resultado;

  assign rodada_in = VenceA || VenceB || Empate;
  assign grava     = (estado == JOGA) && !decidida && rodada_in;
  assign resultado = VenceA ? GANHA_A : (VenceB ? GANHA_B : EMPATE);

  historico_rodadas u_hist (
    .clk          (Clk),
    .clr          (Clr),
    .grava        (grava),
    .limpa        (estado == LIMPA),
    .resultado    (resultado),
    .decidida     (decidida),
    .vencedor_mao (vencedor_mao),
    .sem_pontos   (sem_pontos)
  );

  // State and every output register; reset wins over everything
  always_ff @(posedge Clk) begin
    if (Clr) begin
      estado     <= JOGA;
      ganhador   <= EQUIPE_A;
      requerente <= EQUIPE_A;
      conta      <= 3'd0;
      pontos     <= 4'd0;
      IncA       <= 1'b0;
      IncB       <= 1'b0;
      ClrM       <= 1'b0;
      Valor      <= 3'd1;
      Vez        <= EQUIPE_A;
      Pedido     <= 1'b0;
      FimJogo    <= 1'b0;
      Vencedor   <= 1'b0;
    end else begin
      estado     <= estado_n;
      ganhador   <= ganhador_n;
      requerente <= requerente_n;
      conta      <= conta_n;
      pontos     <= pontos_n;
      IncA       <= inca_n;
      IncB       <= incb_n;
      ClrM       <= clrm_n;
      Valor      <= valor_n;
      Vez        <= vez_n;
      Pedido     <= pedido_n;
      FimJogo    <= fim_n;
      Vencedor   <= venc_n;
    end
  end

  // Next state and next registered outputs
  always_comb begin
    estado_n     = estado;
    ganhador_n   = ganhador;
    requerente_n = requerente;
    conta_n      = conta;
    pontos_n     = pontos;
    inca_n       = 1'b0;
    incb_n       = 1'b0;
    clrm_n       = 1'b0;
    valor_n      = Valor;
    vez_n        = Vez;
    pedido_n     = Pedido;
    fim_n        = FimJogo;
    venc_n       = Vencedor;
    case (estado)
      JOGA: begin
        if (decidida) begin
          if (sem_pontos) begin
            estado_n = LIMPA;
            clrm_n   = 1'b1;
            valor_n  = 3'd1;
            vez_n    = ~Vez;
          end else begin
            estado_n   = PONTUA;
            ganhador_n = vencedor_mao;
            conta_n    = Valor;
            pontos_n   = {1'b0, (vencedor_mao == EQUIPE_B) ? PB : PA};
          end
        end else if (!rodada_in && Truco && (Valor < VMAX)) begin
          estado_n     = PEDIDO;
          pedido_n     = 1'b1;
          requerente_n = Vez;
        end
      end
      PEDIDO: begin
        if (Corre) begin
          estado_n   = PONTUA;
          pedido_n   = 1'b0;
          ganhador_n = requerente;
          conta_n    = Valor;
          pontos_n   = {1'b0, (requerente == EQUIPE_B) ? PB : PA};
        end else if (Aceita) begin
          estado_n = JOGA;
          pedido_n = 1'b0;
          valor_n  = Valor + 3'd1;
          vez_n    = ~Vez;
        end
      end
      PONTUA: begin
        // pontos tracks the winner's score including pulses already sent,
        // so the external 3-bit counter is never pushed past the target
        if ((conta != 3'd0) && (pontos < META)) begin
          conta_n  = conta - 3'd1;
          pontos_n = pontos + 4'd1;
          inca_n   = (ganhador == EQUIPE_A);
          incb_n   = (ganhador == EQUIPE_B);
        end else if (pontos >= META) begin
          estado_n = FIM;
          fim_n    = 1'b1;
          venc_n   = ganhador;
        end else begin
          estado_n = LIMPA;
          clrm_n   = 1'b1;
          valor_n  = 3'd1;
          vez_n    = ~ganhador;
        end
      end
      LIMPA:   estado_n = JOGA;
      FIM:     estado_n = FIM;
      default: estado_n = JOGA;
    endcase
  end

endmodule

// File: tb/tb_controle_mao.sv
// tb/tb_controle_mao.sv - directed table-driven bench for controle_mao
module tb_controle_mao;

  logic       Clk = 1'b0;
  logic       Clr, VenceA, VenceB, Empate, Truco, Aceita, Corre;
  logic [2:0] PA, PB;
  logic       IncA, IncB, ClrM, Vez, Pedido, FimJogo, Vencedor;
  logic [2:0] Valor;
  logic       carrega_a;
  logic [2:0] carga_a;
  int         checks = 0;
  int         errors = 0;

  always #5 Clk = ~Clk;

  controle_mao #(.PONTOS_JOGO(7), .VALOR_MAX(4)) dut (
    .Clk(Clk), .Clr(Clr), .VenceA(VenceA), .VenceB(VenceB), .Empate(Empate),
    .Truco(Truco), .Aceita(Aceita), .Corre(Corre), .PA(PA), .PB(PB),
    .IncA(IncA), .IncB(IncB), .ClrM(ClrM), .Valor(Valor), .Vez(Vez),
    .Pedido(Pedido), .FimJogo(FimJogo), .Vencedor(Vencedor)
  );

  // External 3-bit score counters fed by the increment pulses
  always @(posedge Clk) begin
    if (Clr) begin
      PA <= 3'd0;
      PB <= 3'd0;
    end else begin
      if (carrega_a) PA <= carga_a;
      else if (IncA) PA <= PA + 3'd1;
      if (IncB) PB <= PB + 3'd1;
    end
  end

  localparam logic [6:0] I_ID  = 7'b0000000;
  localparam logic [6:0] I_CLR = 7'b1000000;
  localparam logic [6:0] I_VA  = 7'b0100000;
  localparam logic [6:0] I_VB  = 7'b0010000;
  localparam logic [6:0] I_EM  = 7'b0001000;
  localparam logic [6:0] I_TR  = 7'b0000100;
  localparam logic [6:0] I_AC  = 7'b0000010;
  localparam logic [6:0] I_CO  = 7'b0000001;
  localparam logic [9:0] RESET_OUT = {3'b000, 3'd1, 4'b0000};

  // ent = {Clr,VenceA,VenceB,Empate,Truco,Aceita,Corre}
  // sai = {IncA,IncB,ClrM, Valor, Vez,Pedido,FimJogo,Vencedor, PA, PB}
  typedef struct packed {
    logic [6:0]  ent;
    logic [15:0] sai;
  } vetor_t;

  localparam int NV = 42;
  vetor_t tab [NV];

  function automatic vetor_t r(input logic [6:0] e, input logic [2:0] inc, input logic [2:0] v,
                               input logic [3:0] f, input logic [2:0] a, input logic [2:0] b);
    return {e, inc, v, f, a, b};
  endfunction

  function automatic logic [15:0] saida();
    return {IncA, IncB, ClrM, Valor, Vez, Pedido, FimJogo, Vencedor, PA, PB};
  endfunction

  task automatic aplica(input logic [6:0] e);
    {Clr, VenceA, VenceB, Empate, Truco, Aceita, Corre} = e;
  endtask

  task automatic passo(input logic [6:0] e);
    @(negedge Clk);
    aplica(e);
    @(posedge Clk);
    #1;
  endtask

  task automatic checa(input string nome, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nome, got, exp);
    end
  endtask

  int  pulsos_a, pulsos_b, limpezas, extras;
  logic fim_visto;

  initial begin
    aplica(I_CLR);
    carrega_a = 1'b0;
    carga_a   = 3'd0;

    tab[0]  = r(I_CLR,       3'b000, 3'd1, 4'b0000, 3'd0, 3'd0);
    tab[1]  = r(I_VA,        3'b000, 3'd1, 4'b0000, 3'd0, 3'd0);
    tab[2]  = r(I_VA,        3'b000, 3'd1, 4'b0000, 3'd0, 3'd0);
    tab[3]  = r(I_ID,        3'b000, 3'd1, 4'b0000, 3'd0, 3'd0);
    tab[4]  = r(I_ID,        3'b100, 3'd1, 4'b0000, 3'd0, 3'd0);
    tab[5]  = r(I_ID,        3'b001, 3'd1, 4'b1000, 3'd1, 3'd0);
    tab[6]  = r(I_ID,        3'b000, 3'd1, 4'b1000, 3'd1, 3'd0);
    tab[7]  = r(I_TR,        3'b000, 3'd1, 4'b1100, 3'd1, 3'd0);
    tab[8]  = r(I_AC,        3'b000, 3'd2, 4'b0000, 3'd1, 3'd0);
    tab[9]  = r(I_TR,        3'b000, 3'd2, 4'b0100, 3'd1, 3'd0);
    tab[10] = r(I_AC,        3'b000, 3'd3, 4'b1000, 3'd1, 3'd0);
    tab[11] = r(I_VB,        3'b000, 3'd3, 4'b1000, 3'd1, 3'd0);
    tab[12] = r(I_VB,        3'b000, 3'd3, 4'b1000, 3'd1, 3'd0);
    tab[13] = r(I_ID,        3'b000, 3'd3, 4'b1000, 3'd1, 3'd0);
    tab[14] = r(I_ID,        3'b010, 3'd3, 4'b1000, 3'd1, 3'd0);
    tab[15] = r(I_ID,        3'b010, 3'd3, 4'b1000, 3'd1, 3'd1);
    tab[16] = r(I_ID,        3'b010, 3'd3, 4'b1000, 3'd1, 3'd2);
    tab[17] = r(I_ID,        3'b001, 3'd1, 4'b0000, 3'd1, 3'd3);
    tab[18] = r(I_ID,        3'b000, 3'd1, 4'b0000, 3'd1, 3'd3);
    tab[19] = r(I_TR,        3'b000, 3'd1, 4'b0100, 3'd1, 3'd3);
    tab[20] = r(I_CO | I_AC, 3'b000, 3'd1, 4'b0000, 3'd1, 3'd3);
    tab[21] = r(I_AC,        3'b100, 3'd1, 4'b0000, 3'd1, 3'd3);
    tab[22] = r(I_ID,        3'b001, 3'd1, 4'b1000, 3'd2, 3'd3);
    tab[23] = r(I_ID,        3'b000, 3'd1, 4'b1000, 3'd2, 3'd3);
    tab[24] = r(I_EM | I_TR, 3'b000, 3'd1, 4'b1000, 3'd2, 3'd3);
    tab[25] = r(I_VB,        3'b000, 3'd1, 4'b1000, 3'd2, 3'd3);
    tab[26] = r(I_ID,        3'b000, 3'd1, 4'b1000, 3'd2, 3'd3);
    tab[27] = r(I_ID,        3'b010, 3'd1, 4'b1000, 3'd2, 3'd3);
    tab[28] = r(I_ID,        3'b001, 3'd1, 4'b0000, 3'd2, 3'd4);
    tab[29] = r(I_ID,        3'b000, 3'd1, 4'b0000, 3'd2, 3'd4);
    tab[30] = r(I_EM,        3'b000, 3'd1, 4'b0000, 3'd2, 3'd4);
    tab[31] = r(I_EM,        3'b000, 3'd1, 4'b0000, 3'd2, 3'd4);
    tab[32] = r(I_EM,        3'b000, 3'd1, 4'b0000, 3'd2, 3'd4);
    tab[33] = r(I_ID,        3'b001, 3'd1, 4'b1000, 3'd2, 3'd4);
    tab[34] = r(I_ID,        3'b000, 3'd1, 4'b1000, 3'd2, 3'd4);
    tab[35] = r(I_VA | I_VB, 3'b000, 3'd1, 4'b1000, 3'd2, 3'd4);
    tab[36] = r(I_VB,        3'b000, 3'd1, 4'b1000, 3'd2, 3'd4);
    tab[37] = r(I_EM,        3'b000, 3'd1, 4'b1000, 3'd2, 3'd4);
    tab[38] = r(I_ID,        3'b000, 3'd1, 4'b1000, 3'd2, 3'd4);
    tab[39] = r(I_ID,        3'b100, 3'd1, 4'b1000, 3'd2, 3'd4);
    tab[40] = r(I_ID,        3'b001, 3'd1, 4'b1000, 3'd3, 3'd4);
    tab[41] = r(I_ID,        3'b000, 3'd1, 4'b1000, 3'd3, 3'd4);

    for (int i = 0; i < NV; i++) begin
      passo(tab[i].ent);
      checa($sformatf("vetor_%0d", i), saida(), tab[i].sai);
    end

    // Score near target: stake 3 but only one point fits before 7
    @(negedge Clk);
    aplica(I_ID);
    carrega_a = 1'b1;
    carga_a   = 3'd6;
    @(negedge Clk);
    carrega_a = 1'b0;
    checa("carga_pa", 16'(PA), 16'd6);
    passo(I_TR); passo(I_AC); passo(I_TR); passo(I_AC);
    checa("valor_3", 16'({Valor, Vez}), 16'({3'd3, 1'b1}));
    passo(I_VA); passo(I_VA); passo(I_ID);
    pulsos_a = 0; pulsos_b = 0; limpezas = 0; fim_visto = 1'b0;
    for (int k = 0; k < 10 && !fim_visto; k++) begin
      passo(I_ID);
      pulsos_a += int'(IncA);
      pulsos_b += int'(IncB);
      limpezas += int'(ClrM);
      fim_visto = FimJogo;
    end
    checa("fim_alcancado", 16'(fim_visto), 16'd1);
    checa("pulsos_a_sat", 16'(pulsos_a), 16'd1);
    checa("pulsos_b_sat", 16'(pulsos_b), 16'd0);
    checa("sem_clrm_fim", 16'(limpezas), 16'd0);
    checa("vencedor_a", 16'(Vencedor), 16'd0);
    checa("pa_7", 16'(PA), 16'd7);
    extras = 0;
    passo(I_VB); extras += int'(IncA | IncB | ClrM);
    passo(I_VB); extras += int'(IncA | IncB | ClrM);
    passo(I_ID); extras += int'(IncA | IncB | ClrM);
    passo(I_TR); extras += int'(IncA | IncB | ClrM);
    passo(I_CO); extras += int'(IncA | IncB | ClrM);
    checa("fim_ignora", 16'(extras), 16'd0);
    checa("fim_sticky", 16'({FimJogo, Vencedor, Pedido}), 16'(3'b100));
    checa("placar_fim", 16'({PA, PB}), 16'({3'd7, 3'd4}));

    // Reset out of FIM, raise to max stake, then reset mid-scoring
    passo(I_CLR);
    checa("reset_fim", saida(), {RESET_OUT, 3'd0, 3'd0});
    passo(I_TR); passo(I_AC); passo(I_TR); passo(I_AC); passo(I_TR); passo(I_AC);
    checa("valor_max", 16'({Valor, Vez}), 16'({3'd4, 1'b1}));
    passo(I_TR);
    checa("truco_no_max", 16'({Pedido, Valor}), 16'({1'b0, 3'd4}));
    passo(I_VB); passo(I_VB); passo(I_ID);
    passo(I_ID);
    checa("primeiro_incb", 16'({IncA, IncB}), 16'(2'b01));
    passo(I_CLR);
    checa("reset_pontua", saida(), {RESET_OUT, 3'd0, 3'd0});
    extras = 0;
    for (int k = 0; k < 5; k++) begin
      passo(I_ID);
      extras += int'(IncA | IncB | ClrM);
    end
    checa("sem_inc_apos_clr", 16'(extras), 16'd0);
    checa("estado_pos_clr", saida(), {RESET_OUT, 3'd0, 3'd0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
